// File: rtl/pc_sequencer.sv
// PC sequencer: generates the fetch address each cycle from redirect, call,
// return, stall or sequential stepping, with a circular return-address stack
// and a PC limit that folds out-of-range targets back to the reset vector.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] PC_LIMIT     = WIDTH'(100),
  parameter logic [WIDTH-1:0] STEP         = WIDTH'(4),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] RedirectPC,
  input  logic             Call,
  input  logic [WIDTH-1:0] CallPC,
  input  logic             Return,
  output logic [WIDTH-1:0] PC,
  output logic             WrapPulse,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasOverflow,
  output logic             RasUnderflow
);

  localparam int unsigned      PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    ACT_REDIRECT,
    ACT_RETURN,
    ACT_CALL,
    ACT_HOLD,
    ACT_SEQ
  } action_t;

  logic [WIDTH-1:0] rasMem [RAS_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] wrPtrNext;
  logic [PTR_W-1:0] topPtr;
  logic [CNT_W-1:0] rasCount;
  logic [CNT_W-1:0] countNext;
  logic [WIDTH-1:0] seqPC;
  logic [WIDTH-1:0] candPC;
  logic [WIDTH-1:0] pcNext;
  logic             pushEn;
  logic             popEn;
  logic             checkLimit;
  logic             wrapNext;
  logic             overflowSet;
  logic             underflowSet;
  logic             rasEmptyNow;
  logic             rasFullNow;
  action_t          action;

  // Pick the single winning action by priority, form the candidate PC,
  // fold it to the reset vector when past the limit, and plan the RAS update.
  always_comb begin
    seqPC        = PC + STEP;
    topPtr       = wrPtr - PTR_W'(1);
    rasEmptyNow  = (rasCount == '0);
    rasFullNow   = (rasCount == DEPTH_CNT);
    action       = ACT_SEQ;
    candPC       = seqPC;
    pushEn       = 1'b0;
    popEn        = 1'b0;
    checkLimit   = 1'b1;
    overflowSet  = 1'b0;
    underflowSet = 1'b0;
    wrPtrNext    = wrPtr;
    countNext    = rasCount;

    if (Redirect)        action = ACT_REDIRECT;
    else if (Stall)      action = ACT_HOLD;
    else if (Return)     action = ACT_RETURN;
    else if (Call)       action = ACT_CALL;

    case (action)
      ACT_REDIRECT: candPC = RedirectPC;
      ACT_RETURN: begin
        if (rasEmptyNow) begin
          candPC       = RESET_VECTOR;
          underflowSet = 1'b1;
        end else begin
          candPC = rasMem[topPtr];
          popEn  = 1'b1;
        end
      end
      ACT_CALL: begin
        candPC      = CallPC;
        pushEn      = 1'b1;
        overflowSet = rasFullNow;
      end
      ACT_HOLD: begin
        candPC     = PC;
        checkLimit = 1'b0;
      end
      default: candPC = seqPC;
    endcase

    wrapNext = checkLimit && (candPC > PC_LIMIT);
    pcNext   = wrapNext ? RESET_VECTOR : candPC;

    if (pushEn) begin
      wrPtrNext = wrPtr + PTR_W'(1);
      countNext = rasFullNow ? rasCount : rasCount + CNT_W'(1);
    end else if (popEn) begin
      wrPtrNext = topPtr;
      countNext = rasCount - CNT_W'(1);
    end
  end

  // PC, stack bookkeeping and status flags; the error flags are sticky until reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      PC           <= RESET_VECTOR;
      wrPtr        <= '0;
      rasCount     <= '0;
      RasEmpty     <= 1'b1;
      RasFull      <= 1'b0;
      RasOverflow  <= 1'b0;
      RasUnderflow <= 1'b0;
      WrapPulse    <= 1'b0;
    end else begin
      PC        <= pcNext;
      wrPtr     <= wrPtrNext;
      rasCount  <= countNext;
      RasEmpty  <= (countNext == '0);
      RasFull   <= (countNext == DEPTH_CNT);
      WrapPulse <= wrapNext;
      if (overflowSet)  RasOverflow  <= 1'b1;
      if (underflowSet) RasUnderflow <= 1'b1;
    end
  end

  // Return-address storage; a push writes the unchecked PC+STEP at the write
  // pointer, which on a full stack lands on the oldest entry.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) rasMem[i] <= '0;
    end else if (pushEn) begin
      rasMem[wrPtr] <= seqPC;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        Call = 1'b0;
  logic [31:0] CallPC = '0;
  logic        Return = 1'b0;
  logic [31:0] PC;
  logic        WrapPulse;
  logic        RasEmpty;
  logic        RasFull;
  logic        RasOverflow;
  logic        RasUnderflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .Stall(Stall), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .Call(Call), .CallPC(CallPC), .Return(Return),
    .PC(PC), .WrapPulse(WrapPulse), .RasEmpty(RasEmpty), .RasFull(RasFull),
    .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow)
  );

  always #5 Clock = ~Clock;

  task automatic idleInputs();
    Stall = 0; Redirect = 0; RedirectPC = '0; Call = 0; CallPC = '0; Return = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idleInputs();
  endtask

  task automatic doRedirect(input logic [31:0] target);
    Redirect = 1; RedirectPC = target;
    tick();
  endtask

  task automatic doCall(input logic [31:0] target);
    Call = 1; CallPC = target;
    tick();
  endtask

  task automatic doReturn();
    Return = 1;
    tick();
  endtask

  task automatic test_reset();
    #1 Reset_n = 0;
    #1;
    checks++; if (PC !== 32'd0) begin errors++; $display("FAIL reset_pc got %0d expected 0", PC); end
    checks++; if (RasEmpty !== 1'b1 || RasFull !== 1'b0) begin errors++; $display("FAIL reset_ras got empty=%b full=%b expected 1 0", RasEmpty, RasFull); end
    checks++; if (RasOverflow !== 1'b0 || RasUnderflow !== 1'b0 || WrapPulse !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%b unf=%b wrap=%b expected 0 0 0", RasOverflow, RasUnderflow, WrapPulse); end
    tick();
    checks++; if (PC !== 32'd0) begin errors++; $display("FAIL reset_hold_pc got %0d expected 0", PC); end
    Reset_n = 1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (PC !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc step %0d got %0d expected %0d", i, PC, 4 * i); end
    end
    checks++; if (RasEmpty !== 1'b1) begin errors++; $display("FAIL seq_empty got %b expected 1", RasEmpty); end
  endtask

  task automatic test_wrap();
    doRedirect(32'd96);
    checks++; if (PC !== 32'd96) begin errors++; $display("FAIL wrap_setup got %0d expected 96", PC); end
    tick();
    checks++; if (PC !== 32'd100 || WrapPulse !== 1'b0) begin errors++; $display("FAIL wrap_limit got pc=%0d wrap=%b expected 100 0", PC, WrapPulse); end
    tick();
    checks++; if (PC !== 32'd0 || WrapPulse !== 1'b1) begin errors++; $display("FAIL wrap_seq got pc=%0d wrap=%b expected 0 1", PC, WrapPulse); end
    tick();
    checks++; if (PC !== 32'd4 || WrapPulse !== 1'b0) begin errors++; $display("FAIL wrap_pulse_end got pc=%0d wrap=%b expected 4 0", PC, WrapPulse); end
    doRedirect(32'd101);
    checks++; if (PC !== 32'd0 || WrapPulse !== 1'b1) begin errors++; $display("FAIL wrap_redirect101 got pc=%0d wrap=%b expected 0 1", PC, WrapPulse); end
    doRedirect(32'd100);
    checks++; if (PC !== 32'd100 || WrapPulse !== 1'b0) begin errors++; $display("FAIL wrap_redirect100 got pc=%0d wrap=%b expected 100 0", PC, WrapPulse); end
  endtask

  task automatic test_call_return();
    doRedirect(32'd8);
    doCall(32'd40);
    checks++; if (PC !== 32'd40 || RasEmpty !== 1'b0) begin errors++; $display("FAIL call_pc got pc=%0d empty=%b expected 40 0", PC, RasEmpty); end
    doReturn();
    checks++; if (PC !== 32'd12 || RasEmpty !== 1'b1) begin errors++; $display("FAIL return_pc got pc=%0d empty=%b expected 12 1", PC, RasEmpty); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] expRet [4];
    expRet[0] = 32'd68; expRet[1] = 32'd52; expRet[2] = 32'd36; expRet[3] = 32'd20;
    doRedirect(32'd0);
    for (int k = 1; k <= 4; k++) doCall(32'(16 * k));
    checks++; if (RasFull !== 1'b1 || RasOverflow !== 1'b0) begin errors++; $display("FAIL ras_fill got full=%b ovf=%b expected 1 0", RasFull, RasOverflow); end
    doCall(32'd80);
    checks++; if (PC !== 32'd80 || RasFull !== 1'b1 || RasOverflow !== 1'b1) begin errors++; $display("FAIL ras_overflow got pc=%0d full=%b ovf=%b expected 80 1 1", PC, RasFull, RasOverflow); end
    for (int k = 0; k < 4; k++) begin
      doReturn();
      checks++; if (PC !== expRet[k]) begin errors++; $display("FAIL ras_pop %0d got %0d expected %0d", k, PC, expRet[k]); end
    end
    checks++; if (RasEmpty !== 1'b1 || RasFull !== 1'b0) begin errors++; $display("FAIL ras_drained got empty=%b full=%b expected 1 0", RasEmpty, RasFull); end
    doReturn();
    checks++; if (PC !== 32'd0 || RasUnderflow !== 1'b1) begin errors++; $display("FAIL ras_underflow got pc=%0d unf=%b expected 0 1", PC, RasUnderflow); end
    tick();
    checks++; if (RasUnderflow !== 1'b1 || RasOverflow !== 1'b1) begin errors++; $display("FAIL ras_sticky got unf=%b ovf=%b expected 1 1", RasUnderflow, RasOverflow); end
  endtask

  task automatic test_call_wrap();
    doRedirect(32'd96);
    doCall(32'd200);
    checks++; if (PC !== 32'd0 || WrapPulse !== 1'b1 || RasEmpty !== 1'b0) begin errors++; $display("FAIL callwrap got pc=%0d wrap=%b empty=%b expected 0 1 0", PC, WrapPulse, RasEmpty); end
    doReturn();
    checks++; if (PC !== 32'd100 || WrapPulse !== 1'b0) begin errors++; $display("FAIL callwrap_ret got pc=%0d wrap=%b expected 100 0", PC, WrapPulse); end
    doCall(32'd8);
    doReturn();
    checks++; if (PC !== 32'd0 || WrapPulse !== 1'b1) begin errors++; $display("FAIL ret_wrap got pc=%0d wrap=%b expected 0 1", PC, WrapPulse); end
  endtask

  task automatic test_stall();
    doRedirect(32'd20);
    doCall(32'd40);
    Stall = 1; Call = 1; CallPC = 32'd60;
    tick();
    checks++; if (PC !== 32'd40 || RasEmpty !== 1'b0 || RasFull !== 1'b0) begin errors++; $display("FAIL stall_call got pc=%0d empty=%b full=%b expected 40 0 0", PC, RasEmpty, RasFull); end
    Stall = 1; Return = 1;
    tick();
    checks++; if (PC !== 32'd40 || RasEmpty !== 1'b0) begin errors++; $display("FAIL stall_return got pc=%0d empty=%b expected 40 0", PC, RasEmpty); end
    Stall = 1; Redirect = 1; RedirectPC = 32'd20;
    tick();
    checks++; if (PC !== 32'd20) begin errors++; $display("FAIL stall_redirect got %0d expected 20", PC); end
    doReturn();
    checks++; if (PC !== 32'd24 || RasEmpty !== 1'b1) begin errors++; $display("FAIL stall_ras_intact got pc=%0d empty=%b expected 24 1", PC, RasEmpty); end
  endtask

  task automatic test_back_to_back();
    doRedirect(32'd8);
    doCall(32'd40);
    Call = 1; CallPC = 32'd60; Return = 1;
    tick();
    checks++; if (PC !== 32'd12 || RasEmpty !== 1'b1) begin errors++; $display("FAIL call_and_return got pc=%0d empty=%b expected 12 1", PC, RasEmpty); end
    Redirect = 1; RedirectPC = 32'd48; Return = 1; Call = 1; CallPC = 32'd4;
    tick();
    checks++; if (PC !== 32'd48 || RasEmpty !== 1'b1) begin errors++; $display("FAIL redirect_priority got pc=%0d empty=%b expected 48 1", PC, RasEmpty); end
  endtask

  task automatic test_async_reset();
    doRedirect(32'd8);
    doCall(32'd40);
    doCall(32'd60);
    #2 Reset_n = 0;
    #1;
    checks++; if (PC !== 32'd0 || RasEmpty !== 1'b1) begin errors++; $display("FAIL async_reset got pc=%0d empty=%b expected 0 1", PC, RasEmpty); end
    checks++; if (RasOverflow !== 1'b0 || RasUnderflow !== 1'b0 || WrapPulse !== 1'b0) begin errors++; $display("FAIL async_flags got ovf=%b unf=%b wrap=%b expected 0 0 0", RasOverflow, RasUnderflow, WrapPulse); end
    #2 Reset_n = 1;
    doRedirect(32'd200);
    checks++; if (PC !== 32'd0 || WrapPulse !== 1'b1) begin errors++; $display("FAIL post_reset_redirect got pc=%0d wrap=%b expected 0 1", PC, WrapPulse); end
    doReturn();
    checks++; if (PC !== 32'd0 || RasUnderflow !== 1'b1) begin errors++; $display("FAIL post_reset_ras got pc=%0d unf=%b expected 0 1", PC, RasUnderflow); end
  endtask

  // Bound the whole run so a stuck simulation still ends with a report.
  initial begin
    #50000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  // Run every scenario in order, then print the summary.
  initial begin
    $display("[TB] starting pc_sequencer bench");
    test_reset();
    test_sequential();
    test_wrap();
    test_call_return();
    test_ras_overflow();
    test_call_wrap();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
